// File: rtl/lfsr_checker.sv
// lfsr_checker
//   Receive-side checker for an 8-bit Fibonacci LFSR random-number stream.
//   The checker seeds a local LFSR copy from incoming samples and declares
//   lock after LOCK_COUNT consecutive correct predictions. While locked it
//   runs freely from its own state, then flags and counts every mismatch.
//   It drops lock after UNLOCK_ERRS consecutive mismatches.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   in_valid      sample qualifier, one sample per high cycle
//   random_num_i  incoming random number
//   clear_i       synchronous clear of err_cnt_o and sample_cnt_o only
//   locked_o      high while in LOCKED
//   err_o         one-cycle pulse per mismatch detected while locked
//   err_cnt_o     saturating count of mismatches seen while locked
//   sample_cnt_o  saturating count of samples accepted while locked
//   pred_o        value expected on the next accepted sample
module lfsr_checker #(
  parameter int unsigned        S_WIDTH     = 8,
  parameter logic [S_WIDTH-1:0] TAPS        = 'hB8,
  parameter int unsigned        LOCK_COUNT  = 4,
  parameter int unsigned        UNLOCK_ERRS = 3,
  parameter int unsigned        CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [S_WIDTH-1:0]   random_num_i,
  input  logic                 clear_i,
  output logic                 locked_o,
  output logic                 err_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  output logic [CNT_WIDTH-1:0] sample_cnt_o,
  output logic [S_WIDTH-1:0]   pred_o
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_THR   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_THR = 4'(UNLOCK_ERRS);

  state_t               state, state_nxt;
  logic [S_WIDTH-1:0]   pred, pred_nxt;
  logic [3:0]           match_cnt, match_cnt_nxt;
  logic [3:0]           bad_run, bad_run_nxt;
  logic                 err, err_nxt;
  logic [CNT_WIDTH-1:0] err_cnt, err_cnt_nxt;
  logic [CNT_WIDTH-1:0] sample_cnt, sample_cnt_nxt;

  logic                 sample_zero;
  logic                 sample_hit;
  logic [3:0]           match_inc;
  logic [3:0]           bad_inc;

  function automatic logic [S_WIDTH-1:0] lfsr_next(input logic [S_WIDTH-1:0] s);
    return {s[S_WIDTH-2:0], ^(s & TAPS)};
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == '1) ? c : c + CNT_WIDTH'(1);
  endfunction

  assign sample_zero = (random_num_i == '0);
  assign sample_hit  = (random_num_i == pred);
  assign match_inc   = match_cnt + 4'd1;
  assign bad_inc     = bad_run + 4'd1;

  always_comb begin
    state_nxt      = state;
    pred_nxt       = pred;
    match_cnt_nxt  = match_cnt;
    bad_run_nxt    = bad_run;
    err_nxt        = 1'b0;
    err_cnt_nxt    = err_cnt;
    sample_cnt_nxt = sample_cnt;

    if (in_valid) begin
      case (state)
        HUNT: begin
          // All-zero is the LFSR lockup value, so it can never seed.
          if (!sample_zero) begin
            pred_nxt      = lfsr_next(random_num_i);
            match_cnt_nxt = '0;
            state_nxt     = VERIFY;
          end
        end
        VERIFY: begin
          if (sample_hit) begin
            match_cnt_nxt = match_inc;
            pred_nxt      = lfsr_next(random_num_i);
            if (match_inc == LOCK_THR) begin
              state_nxt   = LOCKED;
              bad_run_nxt = '0;
            end
          end else if (!sample_zero) begin
            pred_nxt      = lfsr_next(random_num_i);
            match_cnt_nxt = '0;
          end else begin
            state_nxt = HUNT;
          end
        end
        LOCKED: begin
          // Flywheel on the local state; data never reseeds while locked.
          sample_cnt_nxt = sat_inc(sample_cnt);
          pred_nxt       = lfsr_next(pred);
          if (sample_hit) begin
            bad_run_nxt = '0;
          end else begin
            err_nxt     = 1'b1;
            err_cnt_nxt = sat_inc(err_cnt);
            bad_run_nxt = bad_inc;
            if (bad_inc == UNLOCK_THR) state_nxt = HUNT;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end

    // Clear wins over a same-cycle increment; the error pulse is unaffected.
    if (clear_i) begin
      err_cnt_nxt    = '0;
      sample_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      pred       <= '0;
      match_cnt  <= '0;
      bad_run    <= '0;
      err        <= 1'b0;
      err_cnt    <= '0;
      sample_cnt <= '0;
    end else begin
      state      <= state_nxt;
      pred       <= pred_nxt;
      match_cnt  <= match_cnt_nxt;
      bad_run    <= bad_run_nxt;
      err        <= err_nxt;
      err_cnt    <= err_cnt_nxt;
      sample_cnt <= sample_cnt_nxt;
    end
  end

  assign locked_o     = (state == LOCKED);
  assign err_o        = err;
  assign err_cnt_o    = err_cnt;
  assign sample_cnt_o = sample_cnt;
  assign pred_o       = pred;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker
//   Directed plus randomized stimulus for lfsr_checker (counters narrowed to
//   4 bits so saturation is reachable), checked against a behavioural model.
module tb_lfsr_checker;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [7:0]    random_num_i;
  logic          clear_i;
  logic          locked_o;
  logic          err_o;
  logic [CW-1:0] err_cnt_o;
  logic [CW-1:0] sample_cnt_o;
  logic [7:0]    pred_o;

  lfsr_checker #(
    .S_WIDTH     (8),
    .TAPS        (8'hB8),
    .LOCK_COUNT  (4),
    .UNLOCK_ERRS (3),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .random_num_i (random_num_i),
    .clear_i      (clear_i),
    .locked_o     (locked_o),
    .err_o        (err_o),
    .err_cnt_o    (err_cnt_o),
    .sample_cnt_o (sample_cnt_o),
    .pred_o       (pred_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: "seeded" means a prediction is being verified,
  // "locked" means the local generator runs on its own.
  bit       m_locked, m_seeded, m_err;
  int       m_run, m_bad, m_ecnt, m_scnt;
  int       m_pred;

  // Polynomial x^8+x^6+x^5+x^4+1: shift left, feedback is tap parity.
  function automatic int poly_next(input int s);
    logic [7:0] t;
    t = 8'(s);
    return ((s * 2) % 256) + ($countones(t & 8'hB8) % 2);
  endfunction

  function automatic int sat(input int c);
    return (c >= CMAX) ? CMAX : c + 1;
  endfunction

  task automatic model(input bit v, input int d, input bit c, input bit r);
    if (r) begin
      m_locked = 0; m_seeded = 0; m_err = 0;
      m_run = 0; m_bad = 0; m_ecnt = 0; m_scnt = 0; m_pred = 0;
      return;
    end
    m_err = 0;
    if (v) begin
      if (m_locked) begin
        m_scnt = sat(m_scnt);
        if (d == m_pred) m_bad = 0;
        else begin
          m_err  = 1;
          m_ecnt = sat(m_ecnt);
          m_bad  = m_bad + 1;
          if (m_bad == 3) begin m_locked = 0; m_seeded = 0; end
        end
        m_pred = poly_next(m_pred);
      end else if (m_seeded && d == m_pred) begin
        m_run  = m_run + 1;
        m_pred = poly_next(d);
        if (m_run == 4) begin m_locked = 1; m_bad = 0; end
      end else if (d != 0) begin
        m_seeded = 1; m_run = 0; m_pred = poly_next(d);
      end else begin
        m_seeded = 0;
      end
    end
    if (c) begin m_ecnt = 0; m_scnt = 0; end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input int d, input bit c, input bit r);
    @(negedge clk);
    in_valid     = v;
    random_num_i = 8'(d);
    clear_i      = c;
    rst          = r;
    @(posedge clk);
    model(v, d & 255, c, r);
    #1;
    check("locked_o",     32'(locked_o),     32'(m_locked));
    check("err_o",        32'(err_o),        32'(m_err));
    check("err_cnt_o",    32'(err_cnt_o),    32'(m_ecnt));
    check("sample_cnt_o", 32'(sample_cnt_o), 32'(m_scnt));
    check("pred_o",       32'(pred_o),       32'(m_pred));
  endtask

  int lock_seq[5] = '{125, 251, 246, 237, 219};
  int d;

  initial begin
    in_valid = 0; random_num_i = '0; clear_i = 0; rst = 1;

    // Reset state
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("rst_locked", 32'(locked_o), 0);
    check("rst_pred",   32'(pred_o),   0);
    check("rst_ecnt",   32'(err_cnt_o), 0);

    // Lock acquisition
    foreach (lock_seq[i]) step(1, lock_seq[i], 0, 0);
    check("lock_up",   32'(locked_o),     1);
    check("lock_pred", 32'(pred_o),       183);
    check("lock_scnt", 32'(sample_cnt_o), 0);

    // Single error while locked
    step(1, 183, 0, 0);
    step(1, 0, 0, 0);
    check("single_err_pulse", 32'(err_o),     1);
    check("single_err_cnt",   32'(err_cnt_o), 1);
    step(1, 222, 0, 0);
    check("single_err_gone", 32'(err_o),        0);
    check("single_held",     32'(locked_o),     1);
    check("single_scnt",     32'(sample_cnt_o), 3);

    // Sparse valid, then clear on the same edge as an erroneous sample
    repeat (12) begin
      repeat ($urandom_range(0, 5)) step(0, $urandom_range(0, 255), 0, 0);
      step(1, m_pred, 0, 0);
    end
    step(1, m_pred ^ 8'h5A, 1, 0);
    check("clr_err_pulse", 32'(err_o),     1);
    check("clr_err_cnt",   32'(err_cnt_o), 0);

    // Loss of lock after three consecutive errors, then reseed
    step(1, m_pred, 0, 0);
    for (int i = 0; i < 3; i++) step(1, m_pred ^ $urandom_range(1, 255), 0, 0);
    check("unlock_cnt", 32'(err_cnt_o), 3);
    check("unlock_lo",  32'(locked_o),  0);
    step(1, $urandom_range(1, 255), 0, 0);
    check("reseed_locked", 32'(locked_o), 0);

    // Zeros ignored in HUNT, then seed and reseed in VERIFY
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("zero_hunt_pred", 32'(pred_o), 0);
    step(1, 87, 0, 0);
    check("seed87_pred", 32'(pred_o), 175);
    step(1, 10, 0, 0);
    check("reseed10_pred", 32'(pred_o), 21);
    check("reseed10_err",  32'(err_o),  0);

    // Lock from a random seed, then saturate the error counter
    step(1, $urandom_range(1, 255), 0, 0);
    repeat (4) step(1, m_pred, 0, 0);
    check("relock", 32'(locked_o), 1);
    repeat (20) begin
      step(1, m_pred ^ $urandom_range(1, 255), 0, 0);
      step(1, m_pred, 0, 0);
    end
    check("sat_ecnt",   32'(err_cnt_o), CMAX);
    check("sat_locked", 32'(locked_o),  1);

    // Randomized soak
    repeat (400) begin
      d = ($urandom_range(0, 3) != 0) ? m_pred : $urandom_range(0, 255);
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 19) == 0, 0);
    end

    // Mid-stream reset overrides valid and clear
    step(1, $urandom_range(1, 255), 0, 0);
    repeat (6) step(1, m_pred, 0, 0);
    step(1, m_pred ^ 8'h33, 1, 1);
    check("midrst_locked", 32'(locked_o),     0);
    check("midrst_err",    32'(err_o),        0);
    check("midrst_ecnt",   32'(err_cnt_o),    0);
    check("midrst_scnt",   32'(sample_cnt_o), 0);
    check("midrst_pred",   32'(pred_o),       0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
